// File: rtl/rr_arbiter4_pkg.sv
// rr_arbiter4_pkg -- definitions shared by the round-robin arbiter and its bench.
//   arb_state_e       : FSM state encoding (IDLE=0, GRANT=1)
//   DEFAULT_MAX_HOLD  : default hold limit for a single grant
//   HOLD_W            : hold counter width, wide enough for MAX_HOLD up to 255
package rr_arbiter4_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned DEFAULT_MAX_HOLD = 8;
    localparam int unsigned HOLD_W           = 8;

endpackage

// File: rtl/rr_arbiter4_decoder2to4.sv
// decoder2to4 -- plain 2-to-4 one-hot decoder.
//   a : index MSB
//   b : index LSB
//   y : one-hot output, bit {a,b} set
module decoder2to4 (
    input  logic       a,
    input  logic       b,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b0001 << {a, b};
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- 4-requester round-robin arbiter with a per-grant hold limit.
// A grant is issued from IDLE, held in GRANT until the holder finishes,
// drops its request or hits the hold limit, then the FSM returns to IDLE for
// exactly one cycle before the next arbitration.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   req[3:0]  : level-sensitive requests
//   done      : holder finished (only looked at in GRANT)
//   gnt[3:0]  : one-hot grant, zero when idle
//   gnt_idx   : index of the current/last grant
//   gnt_valid : high whenever gnt is non-zero
//   timeout   : one-cycle pulse after a release caused purely by the hold limit
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);

    arb_state_e        state;
    logic [1:0]        ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        win_idx;
    logic [3:0]        dec_y;
    logic              rel_done;
    logic              rel_drop;
    logic              rel_hold;
    logic              release_now;

    // First asserted request scanning ptr+1 .. ptr+4; the last candidate is
    // ptr itself, so a lone requester wins again after its own release.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] cand;
        logic       found;
        // NOTE: every local gets a value before any branch so no storage is implied.
        rr_pick = p;
        found   = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cand = p + 2'(i);
            if (!found && r[cand]) begin
                rr_pick = cand;
                found   = 1'b1;
            end
        end
    endfunction

    assign win_idx = rr_pick(req, ptr);

    // Release causes, evaluated against the current holder.
    assign rel_done    = done;
    assign rel_drop    = !req[gnt_idx];
    assign rel_hold    = (hold_cnt == HOLD_LAST);
    assign release_now = rel_done || rel_drop || rel_hold;

    always_ff @(posedge clk) begin
        // NOTE: all state here uses <= so every register samples pre-edge values.
        if (rst) begin
            state     <= ST_IDLE;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
            hold_cnt  <= '0;
            ptr       <= 2'd3;
        end else begin
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (hold_cnt != HOLD_SAT) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (release_now) begin
                        state     <= ST_IDLE;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx;
                        // Only a pure hold-limit release is reported.
                        timeout   <= rel_hold && !rel_done && !rel_drop;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    decoder2to4 u_dec (
        .a (gnt_idx[1]),
        .b (gnt_idx[0]),
        .y (dec_y)
    );

    assign gnt = gnt_valid ? dec_y : 4'b0000;

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive cycles one grant may be held (legal 2..255).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: req  input  4  request lines, req[i] from requester i, level-sensitive.
REQ-005 Port: done  input  1  current grant holder finished; sampled only in GRANT.
REQ-006 Port: gnt  output  4  one-hot grant, registered; all-zero when no grant.
REQ-007 Port: gnt_idx  output  2  binary index of granted requester; holds last value when gnt_valid=0.
REQ-008 Port: gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-009 Port: timeout  output  1  one-cycle pulse when a grant is forcibly released by the hold limit.

Function
REQ-010 The FSM SHALL have two states: IDLE and GRANT.
REQ-011 IDLE: if req != 0, SHALL select the winner, load gnt_idx, set gnt_valid=1, clear hold counter, go to GRANT on the next edge; if req == 0, SHALL stay in IDLE with gnt=0.
REQ-012 Winner SHALL be the first asserted req[i] scanning ptr+1, ptr+2, ptr+3, ptr+4 (mod 4), where ptr is the last-granted index.
REQ-013 Grant latency SHALL be exactly 1 cycle: a req first seen in IDLE at edge N gives gnt at edge N+1.
REQ-014 gnt SHALL be the 2-to-4 decode of gnt_idx while gnt_valid=1, else 4'b0000.
REQ-015 GRANT: the hold counter SHALL increment every cycle, saturating at MAX_HOLD.
REQ-016 GRANT: the grant SHALL be released (next state IDLE, gnt=0 next cycle) when done=1, or req[gnt_idx]=0, or the hold counter reaches MAX_HOLD-1.
REQ-017 On every release ptr SHALL be loaded with gnt_idx.
REQ-018 timeout SHALL pulse for the single cycle after a release caused only by the hold limit; it SHALL stay 0 if done or req drop occurs in the same cycle.
REQ-019 After any release the FSM SHALL spend exactly one cycle in IDLE (gnt=0) before the next grant; back-to-back grants are therefore separated by one idle cycle.
REQ-020 Requests asserted or dropped by non-holders during GRANT SHALL have no effect until the next IDLE cycle.
REQ-021 A sole requester SHALL be re-granted after its release if still requesting (wrap-around of scan returns to itself).
REQ-022 done asserted in IDLE SHALL be ignored.
REQ-023 No more than one gnt bit SHALL ever be high.

Reset
REQ-024 On rst=1 at a rising edge: state=IDLE, gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0, hold counter=0, ptr=3 (requester 0 has first priority).
REQ-025 rst SHALL override all other inputs, including mid-grant; the grant SHALL drop the cycle after rst is sampled.
REQ-026 The first grant after rst deasserts SHALL follow REQ-011 from the first non-reset edge.

Structure
REQ-027 State encodings (IDLE=0, GRANT=1) and MAX_HOLD default SHALL live in a shared Verilog include file used by the arbiter and its bench.
REQ-028 One sub-module SHALL be instantiated: the existing decoder2to4 (inputs a=gnt_idx[1], b=gnt_idx[0], output y), gated by gnt_valid, to produce gnt.
REQ-029 Scan logic, FSM, pointer and hold counter SHALL be in rr_arbiter4 itself; target 120-250 lines.

Verification
REQ-030 Reset then req=0000 for 5 cycles -> gnt=0000, gnt_valid=0, timeout=0 throughout.
REQ-031 Reset, req=1111 held, done pulsed 1 cycle after each grant -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-032 req=0100 only, done never asserted, MAX_HOLD=8 -> gnt=0100 for exactly 8 cycles, timeout=1 the next cycle with gnt=0000, then gnt=0100 again one cycle later.
REQ-033 Grant held by 1 (gnt=0010), requester 1 drops req while req[3] rises -> gnt=0000 next cycle, gnt=1000 the cycle after, timeout=0.
REQ-034 rst=1 asserted mid-grant with gnt=0100 -> gnt=0000 next cycle; after release with req=1111, first grant is requester 0.
REQ-035 All scenarios: a checker SHALL assert gnt is one-hot or zero and gnt==decode(gnt_idx) whenever gnt_valid=1.
